// File: rtl/unified_mem_pkg.sv
// rtl/unified_mem_pkg.sv - shared constants, port-select enum and byte-lane merge for unified_mem_arb
// Purpose: default geometry for the unified memory, the select encoding used
//          between the arbiter and the response path, and the helper that
//          merges one byte lane of a partial write.
// Ports:   none (package)
package unified_mem_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DEPTH      = 4096;
  localparam int DEF_STARVE_LIM = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } sel_e;

  // One byte lane of a write: take the new byte when its enable is set.
  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/unified_mem_arb_if.sv
// rtl/unified_mem_arb_if.sv - instruction/data requester bundle for unified_mem_arb
// Purpose: groups the I-port (read-only fetch) and D-port (load/store)
//          request, grant and response signals.
// Ports:   master = requester side (drives req/addr/we/be/wdata),
//          slave  = memory side (drives gnt/rvalid/rdata/err).
interface unified_mem_arb_if import unified_mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_err;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err
  );

endinterface

// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - two-requester data-priority arbiter with I-port starvation counter
// Purpose: grants D over I unless I has been denied STARVE_LIM consecutive
//          requesting cycles; also registers which port was granted so the
//          response strobes line up one cycle later.
// Ports:   clk, rst_n (async active-low); i_req, d_req in;
//          i_gnt, d_gnt out (combinational); sel out (registered grant).
module mem_arb2 import unified_mem_pkg::*; #(
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt,
  output sel_e sel
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] starve_cnt;

  // D wins a conflict until I has waited LIM cycles in a row.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (d_req && (!i_req || (starve_cnt < LIM))) begin
      d_gnt = 1'b1;
    end else if (i_req) begin
      i_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      sel        <= SEL_NONE;
    end else begin
      if (i_gnt) begin
        starve_cnt <= '0;
      end else if (i_req && (starve_cnt < LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      sel <= i_gnt ? SEL_I : (d_gnt ? SEL_D : SEL_NONE);
    end
  end

endmodule

// File: rtl/unified_mem_arb.sv
// rtl/unified_mem_arb.sv - single-array memory shared by an instruction and a data requester
// Purpose: one access per cycle chosen by mem_arb2; byte-enable writes,
//          range checking and registered one-cycle responses.
// Ports:   clk, rst_n (async active-low); bus (unified_mem_arb_if.slave)
//          carrying the I and D request/grant/response signals.
module unified_mem_arb import unified_mem_pkg::*; #(
  parameter int    DATA_W     = DEF_DATA_W,
  parameter int    ADDR_W     = DEF_ADDR_W,
  parameter int    DEPTH      = DEF_DEPTH,
  parameter int    STARVE_LIM = DEF_STARVE_LIM,
  parameter string INIT_FILE  = ""
) (
  input logic               clk,
  input logic               rst_n,
  unified_mem_arb_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic i_gnt;
  logic d_gnt;
  sel_e sel;

  mem_arb2 #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt),
    .sel   (sel)
  );

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;

  logic             i_ok;
  logic             d_ok;
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] d_idx;

  assign i_ok  = ({1'b0, bus.i_addr} < DEPTH_X);
  assign d_ok  = ({1'b0, bus.d_addr} < DEPTH_X);
  assign i_idx = bus.i_addr[IDX_W-1:0];
  assign d_idx = bus.d_addr[IDX_W-1:0];

  logic [DATA_W-1:0] d_merged;

  always_comb begin
    d_merged = mem[d_idx];
    for (int k = 0; k < BE_W; k++) begin
      d_merged[8*k +: 8] = lane_merge(mem[d_idx][8*k +: 8],
                                      bus.d_wdata[8*k +: 8], bus.d_be[k]);
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (d_gnt && bus.d_we && d_ok) begin
      mem[d_idx] <= d_merged;
    end
  end

  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_err_q;
  logic              d_err_q;

  // rdata holds between strobes; err is only meaningful with its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
      if (i_gnt) begin
        i_rdata_q <= i_ok ? mem[i_idx] : '0;
        i_err_q   <= !i_ok;
      end
      if (d_gnt) begin
        d_rdata_q <= (d_ok && !bus.d_we) ? mem[d_idx] : '0;
        d_err_q   <= !d_ok;
      end
    end
  end

  assign bus.i_rvalid = (sel == SEL_I);
  assign bus.d_rvalid = (sel == SEL_D);
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.i_err    = i_err_q;
  assign bus.d_err    = d_err_q;

endmodule

// File: tb/tb_unified_mem_arb.sv
// tb/tb_unified_mem_arb.sv - self-checking bench for unified_mem_arb
module tb_unified_mem_arb;

  localparam int LIM   = 4;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arb_if #(.DATA_W(32), .ADDR_W(16)) bus ();

  unified_mem_arb #(
    .DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .STARVE_LIM(LIM), .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] mmem [int];
  int        m_starve = 0;
  bit        e_i_rvalid = 0, e_i_err = 0, e_d_rvalid = 0, e_d_err = 0;
  bit [31:0] e_i_rdata = 0, e_d_rdata = 0;

  function automatic bit [31:0] mread(input int a);
    return mmem.exists(a) ? mmem[a] : 32'h0;
  endfunction

  always @(negedge clk) begin
    bit gi, gd, ok;
    int ia, da;
    bit [31:0] w;
    if (!rst_n) begin
      chk("rst_i_rvalid", {31'b0, bus.i_rvalid}, 0);
      chk("rst_d_rvalid", {31'b0, bus.d_rvalid}, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_i_err", {31'b0, bus.i_err}, 0);
      chk("rst_d_err", {31'b0, bus.d_err}, 0);
      e_i_rvalid = 0; e_i_err = 0; e_i_rdata = 0;
      e_d_rvalid = 0; e_d_err = 0; e_d_rdata = 0;
      m_starve = 0;
    end else begin
      chk("i_rvalid", {31'b0, bus.i_rvalid}, {31'b0, e_i_rvalid});
      chk("d_rvalid", {31'b0, bus.d_rvalid}, {31'b0, e_d_rvalid});
      chk("i_rdata", bus.i_rdata, e_i_rdata);
      chk("d_rdata", bus.d_rdata, e_d_rdata);
      if (e_i_rvalid) chk("i_err", {31'b0, bus.i_err}, {31'b0, e_i_err});
      if (e_d_rvalid) chk("d_err", {31'b0, bus.d_err}, {31'b0, e_d_err});
      chk("starve_cnt", {28'b0, dut.u_arb.starve_cnt}, m_starve);

      if (bus.i_req && bus.d_req) begin
        gi = (m_starve == LIM);
        gd = !gi;
      end else begin
        gi = bus.i_req;
        gd = bus.d_req;
      end
      chk("i_gnt", {31'b0, bus.i_gnt}, {31'b0, gi});
      chk("d_gnt", {31'b0, bus.d_gnt}, {31'b0, gd});

      e_i_rvalid = gi;
      if (gi) begin
        ia = int'(bus.i_addr);
        ok = ia < DEPTH;
        e_i_rdata = ok ? mread(ia) : 32'h0;
        e_i_err   = !ok;
      end
      e_d_rvalid = gd;
      if (gd) begin
        da = int'(bus.d_addr);
        ok = da < DEPTH;
        e_d_err = !ok;
        if (bus.d_we) begin
          e_d_rdata = 32'h0;
          if (ok) begin
            w = mread(da);
            for (int k = 0; k < 4; k++)
              if (bus.d_be[k]) w[8*k +: 8] = bus.d_wdata[8*k +: 8];
            mmem[da] = w;
          end
        end else begin
          e_d_rdata = ok ? mread(da) : 32'h0;
        end
      end

      if (gi) m_starve = 0;
      else if (bus.i_req && m_starve < LIM) m_starve++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_op(input bit we, input int addr, input bit [31:0] data, input bit [3:0] be);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = 16'(addr);
    bus.d_wdata = data;
    bus.d_be    = be;
    step();
    bus.d_req   = 1'b0;
  endtask

  bit [9:0] gseq;

  initial begin
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) step();
    chk("reset_i_rvalid_lit", {31'b0, bus.i_rvalid}, 0);
    chk("reset_d_rdata_lit", bus.d_rdata, 0);
    rst_n = 1'b1;

    // preload through the D port
    for (int a = 0; a < 8; a++) d_op(1, a, 32'h1000_0000 + 32'(a), 4'hF);
    d_op(1, 20, 32'h0000_000D, 4'hF);
    d_op(1, 21, 32'h0000_0011, 4'hF);
    d_op(1, 4095, 32'h1234_5678, 4'hF);
    step();

    // reset again: array must survive
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;

    // I read of 20 right after reset release
    bus.i_req = 1; bus.i_addr = 16'd20;
    #1 chk("t1_i_gnt_lit", {31'b0, bus.i_gnt}, 1);
    step();
    bus.i_req = 0;
    chk("t1_i_rvalid_lit", {31'b0, bus.i_rvalid}, 1);
    chk("t1_i_rdata_lit", bus.i_rdata, 32'h0000_000D);
    chk("t1_i_err_lit", {31'b0, bus.i_err}, 0);

    // byte-enable write then back-to-back read
    d_op(1, 21, 32'hAABB_CCDD, 4'b0101);
    chk("t2_wr_rvalid_lit", {31'b0, bus.d_rvalid}, 1);
    chk("t2_wr_rdata_lit", bus.d_rdata, 0);
    chk("t2_wr_err_lit", {31'b0, bus.d_err}, 0);
    d_op(0, 21, 0, 4'h0);
    chk("t2_rd_rdata_lit", bus.d_rdata, 32'h00BB_00DD);

    // d_be = 0 write is a no-op with a response
    d_op(1, 21, 32'hFFFF_FFFF, 4'h0);
    chk("t2_be0_rvalid_lit", {31'b0, bus.d_rvalid}, 1);
    d_op(0, 21, 0, 4'h0);
    chk("t2_be0_rdata_lit", bus.d_rdata, 32'h00BB_00DD);

    // continuous contention
    bus.i_req = 1; bus.i_addr = 16'd3;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'd5;
    for (int c = 0; c < 10; c++) begin
      #1 gseq[c] = bus.i_gnt;
      step();
    end
    bus.i_req = 0; bus.d_req = 0;
    chk("t3_grant_seq_lit", {22'b0, gseq}, 32'b10_0001_0000);
    step();

    // out-of-range accesses
    d_op(0, 4096, 0, 4'h0);
    chk("t4_oor_rvalid_lit", {31'b0, bus.d_rvalid}, 1);
    chk("t4_oor_err_lit", {31'b0, bus.d_err}, 1);
    chk("t4_oor_rdata_lit", bus.d_rdata, 0);
    d_op(1, 4096, 32'hDEAD_BEEF, 4'hF);
    chk("t4_oor_wr_err_lit", {31'b0, bus.d_err}, 1);
    d_op(0, 4095, 0, 4'h0);
    chk("t4_4095_lit", bus.d_rdata, 32'h1234_5678);
    bus.i_req = 1; bus.i_addr = 16'hFFFF;
    step();
    bus.i_req = 0;
    chk("t4_i_oor_err_lit", {31'b0, bus.i_err}, 1);
    chk("t4_i_oor_rdata_lit", bus.i_rdata, 0);
    step();

    // reset between a granted write and its response
    bus.i_req = 1; bus.i_addr = 16'd2;
    d_op(0, 6, 0, 4'h0);
    chk("t5_starve1_lit", {28'b0, dut.u_arb.starve_cnt}, 1);
    d_op(1, 30, 32'h0000_0055, 4'hF);
    bus.i_req = 0;
    rst_n = 1'b0;
    #1;
    chk("t5_d_rvalid_lit", {31'b0, bus.d_rvalid}, 0);
    chk("t5_d_rdata_lit", bus.d_rdata, 0);
    chk("t5_starve0_lit", {28'b0, dut.u_arb.starve_cnt}, 0);
    step();
    rst_n = 1'b1;
    d_op(0, 30, 0, 4'h0);
    chk("t5_landed_lit", bus.d_rdata, 32'h0000_0055);

    // I alone, then a single D pre-emption
    bus.i_req = 1; bus.i_addr = 16'd1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t6_i_gnt_lit", {31'b0, bus.i_gnt}, 1);
      step();
      chk("t6_starve0_lit", {28'b0, dut.u_arb.starve_cnt}, 0);
    end
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'd7;
    #1 chk("t6_d_pre_lit", {31'b0, bus.d_gnt}, 1);
    step();
    bus.d_req = 0;
    chk("t6_starve1_lit", {28'b0, dut.u_arb.starve_cnt}, 1);
    #1 chk("t6_i_back_lit", {31'b0, bus.i_gnt}, 1);
    step();
    bus.i_req = 0;
    chk("t6_starve_clr_lit", {28'b0, dut.u_arb.starve_cnt}, 0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
